code_sig_capture: RTL



---
 rtl/code_sig_pkg.sv | 14 +
 rtl/code_sig_capture_misr_step.sv | 29 ++
 rtl/code_sig_capture.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/code_sig_pkg.sv
// Shared types and default constants for the code signature capture block
// and the datapath blocks that feed it.
package code_sig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] SIG_POLY_CCITT   = 16'h1021;
  localparam logic [15:0] SIG_SEED_DEFAULT = 16'hFFFF;

endpackage : code_sig_pkg

// File: rtl/code_sig_capture_misr_step.sv
// One MISR step: shift left, fold the polynomial in when the MSB falls out,
// then XOR the zero-extended code into the low bits.
module misr_step #(
  parameter int CODE_W = 3,
  parameter int SIG_W  = 16
) (
  input  logic [SIG_W-1:0]  sig,
  input  logic [CODE_W-1:0] code,
  input  logic [SIG_W-1:0]  poly,
  output logic [SIG_W-1:0]  sig_next
);

  logic [SIG_W-1:0] shifted_s;
  logic [SIG_W-1:0] fold_s;
  logic [SIG_W-1:0] code_ext_s;

  // Next-signature computation
  always_comb begin
    shifted_s  = {sig[SIG_W-2:0], 1'b0};
    code_ext_s = {{(SIG_W-CODE_W){1'b0}}, code};
    if (sig[SIG_W-1]) begin
      fold_s = poly;
    end else begin
      fold_s = {SIG_W{1'b0}};
    end
    sig_next = shifted_s ^ fold_s ^ code_ext_s;
  end

endmodule : misr_step

// File: rtl/code_sig_capture.sv
// Captures a stream of datapath output codes into a MISR signature and a
// saturating per-code histogram over a programmed number of samples.
module code_sig_capture
  import code_sig_pkg::*;
#(
  parameter int              CODE_W   = 3,
  parameter int              SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_POLY_CCITT,
  parameter logic [SIG_W-1:0] SIG_SEED = SIG_SEED_DEFAULT,
  parameter int              CNT_W    = 16,
  parameter int              HIST_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_cnt,
  input  logic [CODE_W-1:0] hist_sel,
  output logic [HIST_W-1:0] hist_count
);

  localparam int NBINS = 1 << CODE_W;
  localparam logic [HIST_W-1:0] HIST_ONE = {{(HIST_W-1){1'b0}}, 1'b1};
  localparam logic [HIST_W-1:0] HIST_MAX = {HIST_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_r;
  logic               in_ready_r;
  logic               busy_r;
  logic               done_r;
  logic [SIG_W-1:0]   sig_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   target_r;
  logic [HIST_W-1:0]  hist_r [NBINS];

  logic [SIG_W-1:0]   sig_next_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               accept_s;

  misr_step #(
    .CODE_W (CODE_W),
    .SIG_W  (SIG_W)
  ) u_misr_step (
    .sig      (sig_r),
    .code     (in_code),
    .poly     (SIG_POLY),
    .sig_next (sig_next_s)
  );

  // Accept qualification and counter increment
  always_comb begin
    accept_s   = in_valid && in_ready_r;
    cnt_next_s = cnt_r + CNT_ONE;
  end

  // Run-control FSM with signature, counter and histogram state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sig_r      <= SIG_SEED;
      cnt_r      <= {CNT_W{1'b0}};
      target_r   <= {CNT_W{1'b0}};
      for (int i = 0; i < NBINS; i++) begin
        hist_r[i] <= {HIST_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            target_r <= num_samples;
            sig_r    <= SIG_SEED;
            cnt_r    <= {CNT_W{1'b0}};
            for (int i = 0; i < NBINS; i++) begin
              hist_r[i] <= {HIST_W{1'b0}};
            end
            // A zero-length run completes without ever opening the input.
            if (num_samples == {CNT_W{1'b0}}) begin
              state_r    <= DONE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              state_r    <= RUN;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b1;
              done_r     <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          if (accept_s) begin
            sig_r <= sig_next_s;
            cnt_r <= cnt_next_s;
            if (hist_r[in_code] != HIST_MAX) begin
              hist_r[in_code] <= hist_r[in_code] + HIST_ONE;
            end else begin
              hist_r[in_code] <= HIST_MAX;
            end
            if (cnt_next_s == target_r) begin
              state_r    <= DONE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  // Output drive from registered state
  always_comb begin
    in_ready   = in_ready_r;
    busy       = busy_r;
    done       = done_r;
    signature  = sig_r;
    sample_cnt = cnt_r;
    hist_count = hist_r[hist_sel];
  end

endmodule : code_sig_capture
